// File: rtl/adder_subtractor.sv
// adder_subtractor
//   Registered two's-complement adder/subtractor with status flags.
//   The result is valid one clock after an accepted input. It wraps modulo
//   2^WIDTH and never saturates.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   qualifies factor_a / factor_b / operation this cycle
//   factor_a   operand A
//   factor_b   operand B
//   operation  0 = A+B, 1 = A-B
//   result     registered sum/difference (signed view)
//   out_valid  one-cycle strobe per accepted input
//   carry_out  add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned)
//   overflow   signed two's-complement overflow
//   zero       result == 0
//   negative   result MSB
module adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic        [WIDTH-1:0] factor_a,
  input  logic        [WIDTH-1:0] factor_b,
  input  logic                    operation,
  output logic signed [WIDTH-1:0] result,
  output logic                    out_valid,
  output logic                    carry_out,
  output logic                    overflow,
  output logic                    zero,
  output logic                    negative
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sum_res;
  logic             ovf_next;

  // Subtraction is A + ~B + 1. The carry-in comes from operation, so add and
  // subtract use one carry chain.
  assign b_eff   = factor_b ^ {WIDTH{operation}};
  assign sum     = {1'b0, factor_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, operation};
  assign sum_res = sum[WIDTH-1:0];

  // Overflow occurs when both addend signs match (after B is conditionally
  // inverted) and the result sign differs from them. For subtraction this is
  // the same as "A and B signs differ, and the result sign differs from A".
  assign ovf_next = (factor_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_res[WIDTH-1] != factor_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= $signed(sum_res);
        carry_out <= sum[WIDTH];
        overflow  <= ovf_next;
        zero      <= (sum_res == '0);
        negative  <= sum_res[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// Testbench for adder_subtractor (WIDTH = 8).
// Inputs are driven after the falling edge. Outputs are sampled at the next
// falling edge, after the rising edge that captured the inputs.
module tb_adder_subtractor;

  localparam int W = 8;
  localparam int OW = W + 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [W-1:0]        factor_a;
  logic [W-1:0]        factor_b;
  logic                operation;
  logic signed [W-1:0] result;
  logic                out_valid;
  logic                carry_out;
  logic                overflow;
  logic                zero;
  logic                negative;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .factor_a  (factor_a),
    .factor_b  (factor_b),
    .operation (operation),
    .result    (result),
    .out_valid (out_valid),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  // Observed output vector: {result, carry, overflow, zero, negative, out_valid}.
  function automatic logic [OW-1:0] observed();
    return {result, carry_out, overflow, zero, negative, out_valid};
  endfunction

  // Reference model using integer arithmetic.
  // Returns {result, carry, overflow, zero, negative}.
  function automatic logic [W+3:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic op);
    int ua, ub, s, res, sa, sb, ss;
    logic c, v, z, n;
    ua = int'(a);
    ub = int'(b);
    s  = op ? ua - ub : ua + ub;
    res = (s + (1 << W)) % (1 << W);
    c  = op ? (ua >= ub) : (s >= (1 << W));
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    ss = op ? sa - sb : sa + sb;
    v  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
    z  = (res == 0);
    n  = (res >= (1 << (W-1)));
    return {res[W-1:0], c, v, z, n};
  endfunction

  localparam logic [OW-1:0] RESET_VEC = {{W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; factor_a = '0; factor_b = '0; operation = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (observed() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", observed(), RESET_VEC);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{8'h36, 8'h36, 8'hB8, 8'hB8, 8'h7F, 8'h80, 8'h00};
    logic [W-1:0] tb [7] = '{8'h15, 8'h15, 8'h57, 8'h57, 8'h01, 8'h80, 8'h01};
    logic         top[7] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    // Expected {result, carry, ovf, zero, neg, out_valid}.
    logic [OW-1:0] texp[7] = '{
      {8'h4B, 5'b00001}, {8'h21, 5'b10001}, {8'h0F, 5'b10001},
      {8'h61, 5'b11001}, {8'h80, 5'b01011}, {8'h00, 5'b10101},
      {8'hFF, 5'b00011}};
    for (int i = 0; i < 7; i++) begin
      factor_a = ta[i]; factor_b = tb[i]; operation = top[i]; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (observed() !== texp[i]) begin
        errors++;
        $display("FAIL directed_%0d: got %h expected %h", i, observed(), texp[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_idle_hold();
    logic [OW-1:0] exp;
    factor_a = 8'h12; factor_b = 8'h34; operation = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    exp = {model(8'h12, 8'h34, 1'b0), 1'b0};
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      factor_a = W'($urandom); factor_b = W'($urandom); operation = 1'($urandom);
      #2 factor_a = W'($urandom);
      @(negedge clk);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL idle_hold_%0d: got %h expected %h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    factor_a = 8'h7F; factor_b = 8'h01; operation = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (observed() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_priority: got %h expected %h", observed(), RESET_VEC);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_discard: got %h expected %h", observed(), RESET_VEC);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] exp;
    for (int i = 0; i < 200; i++) begin
      factor_a = W'($urandom); factor_b = W'($urandom); operation = 1'($urandom);
      in_valid = 1'b1;
      exp = {model(factor_a, factor_b, operation), 1'b1};
      @(negedge clk);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL back_to_back_%0d: got %h expected %h", i, observed(), exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_mixed();
    logic [W+3:0] held;
    logic [OW-1:0] exp;
    // Start from a known held state.
    factor_a = 8'h00; factor_b = 8'h00; operation = 1'b0; in_valid = 1'b1;
    held = model(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      factor_a = W'($urandom); factor_b = W'($urandom); operation = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) held = model(factor_a, factor_b, operation);
      exp = {held, in_valid};
      @(negedge clk);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL random_mixed_%0d: got %h expected %h", i, observed(), exp);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_hold();
    test_reset_priority();
    test_back_to_back();
    test_random_mixed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
